// File: rtl/pic_priority_resolver.sv
// Request, in-service and priority stage of an 8259A-style PIC.
// Define PIC_PRIORITY_RESOLVER_SFNM_EN to honour the SFNM special fully nested mode input.
module pic_priority_resolver #(
  parameter int         NUM_IR          = 8,
  parameter logic [2:0] LOWEST_PRIO_RST = 3'd7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IR-1:0] IR,
  input  logic [NUM_IR-1:0] IM,
  input  logic              LTIM,
  input  logic              AEOI,
  input  logic              SFNM,
  input  logic              first_ACK,
  input  logic              second_ACK,
  input  logic              ocw2_valid,
  input  logic [7:0]        ocw2_data,
  output logic              INT,
  output logic [2:0]        INT_VEC,
  output logic [NUM_IR-1:0] IRR,
  output logic [NUM_IR-1:0] ISR
);

  typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_t;

  state_t            state, state_n;
  logic [NUM_IR-1:0] ir_q, irr_n, isr_set, isr_clr;
  logic              first_ack_q, second_ack_q;
  logic              first_rise, second_rise, second_fall;
  logic [2:0]        ptr, ptr_n;
  logic              rot_aeoi, rot_aeoi_n, spurious;
  logic              cand_found, isr_found, win_valid, sfnm_tie, vec_load, int_n;
  logic [2:0]        cand, isr_top, ocw_l, ocw_cmd;
  logic              unused_in;

  // Highest-priority set bit of v, scanning from p+1 round to p; returns {found, level}.
  function automatic logic [3:0] top_of(input logic [7:0] v, input logic [2:0] p);
    logic [3:0] r;
    r = 4'b0;
    for (int k = 7; k >= 0; k--) begin
      if (v[p + 3'(k + 1)]) r = {1'b1, p + 3'(k + 1)};
    end
    return r;
  endfunction

  function automatic logic [2:0] rank_of(input logic [2:0] idx, input logic [2:0] p);
    return idx - p - 3'd1;
  endfunction

  assign {cand_found, cand}   = top_of(IRR & ~IM, ptr);
  assign {isr_found, isr_top} = top_of(ISR, ptr);

  assign first_rise  = first_ACK & ~first_ack_q;
  assign second_rise = second_ACK & ~second_ack_q;
  assign second_fall = ~second_ACK & second_ack_q;
  assign ocw_cmd     = ocw2_data[7:5];
  assign ocw_l       = ocw2_data[2:0];

`ifdef PIC_PRIORITY_RESOLVER_SFNM_EN
  assign sfnm_tie  = SFNM && cand_found && isr_found && (cand == isr_top);
  assign unused_in = &{1'b0, ocw2_data[4:3]};
`else
  assign sfnm_tie  = 1'b0;
  assign unused_in = &{1'b0, SFNM, ocw2_data[4:3]};
`endif

  assign win_valid = cand_found &&
                     (!isr_found || (rank_of(cand, ptr) < rank_of(isr_top, ptr)) || sfnm_tie);

  // Acknowledge sequencing plus OCW2 decode; OCW2 is applied last so its pointer write wins.
  always_comb begin
    state_n    = state;
    isr_set    = '0;
    isr_clr    = '0;
    ptr_n      = ptr;
    rot_aeoi_n = rot_aeoi;
    vec_load   = 1'b0;
    case (state)
      IDLE: begin
        if (first_rise) begin
          state_n  = ACK1;
          vec_load = 1'b1;
          if (win_valid) isr_set[cand] = 1'b1;
        end
      end
      ACK1: begin
        if (second_rise) state_n = ACK2;
      end
      ACK2: begin
        if (second_fall) begin
          state_n = IDLE;
          if (AEOI && !spurious) begin
            isr_clr[INT_VEC] = 1'b1;
            if (rot_aeoi) ptr_n = INT_VEC;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (ocw2_valid) begin
      case (ocw_cmd)
        3'b001: if (isr_found) isr_clr[isr_top] = 1'b1;
        3'b011: isr_clr[ocw_l] = 1'b1;
        3'b101: begin
          if (isr_found) begin
            isr_clr[isr_top] = 1'b1;
            ptr_n            = isr_top;
          end
        end
        3'b111: begin
          isr_clr[ocw_l] = 1'b1;
          ptr_n          = ocw_l;
        end
        3'b110: ptr_n = ocw_l;
        3'b100: rot_aeoi_n = 1'b1;
        3'b000: rot_aeoi_n = 1'b0;
        default: ;
      endcase
    end
    int_n = (state == IDLE) && (state_n == IDLE) && win_valid;
  end

  // The acknowledged level drops out of IRR in the ack cycle in both trigger modes.
  always_comb begin
    irr_n = IRR;
    for (int i = 0; i < NUM_IR; i++) begin
      if (isr_set[i])   irr_n[i] = 1'b0;
      else if (LTIM)    irr_n[i] = IR[i];
      else if (!IR[i])  irr_n[i] = 1'b0;
      else if (!ir_q[i]) irr_n[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ir_q         <= '0;
      first_ack_q  <= 1'b0;
      second_ack_q <= 1'b0;
      IRR          <= '0;
      ISR          <= '0;
      ptr          <= LOWEST_PRIO_RST;
      rot_aeoi     <= 1'b0;
      spurious     <= 1'b0;
      INT          <= 1'b0;
      INT_VEC      <= 3'd0;
    end else begin
      state        <= state_n;
      ir_q         <= IR;
      first_ack_q  <= first_ACK;
      second_ack_q <= second_ACK;
      IRR          <= irr_n;
      ISR          <= (ISR & ~isr_clr) | isr_set;
      ptr          <= ptr_n;
      rot_aeoi     <= rot_aeoi_n;
      INT          <= int_n;
      if (vec_load) begin
        INT_VEC  <= win_valid ? cand : 3'd7;
        spurious <= !win_valid;
      end
    end
  end

endmodule
